// File: rtl/pic_control_logic.sv
// 8259-style interrupt controller core: ICW/OCW command decode, IRR/ISR/IMR
// registers, fixed-priority resolution (IR0 highest) and the two-pulse INTA handshake.
module pic_control_logic (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:1] ICWs,
    input  logic [3:1] OCWs,
    input  logic [7:0] datatologic,
    input  logic [7:0] ir,
    input  logic       inta_n,
    output logic       intr,
    output logic [7:0] isr,
    output logic [7:0] irr,
    output logic [7:0] imr,
    output logic [7:0] vector,
    output logic       vec_oe,
    output logic       rd_isr
);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        ACK1 = 2'd2
    } state_t;

    state_t     state, next_state;
    logic       ltim, sngl, ic4, aeoi;
    logic [4:0] base;
    logic [2:0] level;
    logic       spurious;
    logic [7:0] ir_prev;
    logic       inta_prev;
    logic       inta_fall;

    logic [7:0] req;
    logic [3:0] isr_top;
    logic       win_found;
    logic [2:0] win_level;

    logic       ack_first, ack_second, ack_end;
    logic [7:0] isr_nxt, irr_nxt;

    assign inta_fall = inta_prev & ~inta_n;
    assign req       = irr & ~imr;
    assign vector    = {base, level};

    // isr_top = 8 means nothing in service, so any request may win
    always_comb begin
        isr_top   = 4'd8;
        win_found = 1'b0;
        win_level = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (isr[i]) isr_top = 4'(i);
        end
        for (int i = 7; i >= 0; i--) begin
            if (req[i] && (4'(i) < isr_top)) begin
                win_found = 1'b1;
                win_level = 3'(i);
            end
        end
    end

    assign intr = (state == RUN) && win_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        ack_first  = 1'b0;
        ack_second = 1'b0;
        ack_end    = 1'b0;
        if (ICWs[1]) begin
            next_state = INIT;
        end else begin
            case (state)
                INIT: begin
                    if (ic4 ? ICWs[4] : (!sngl ? ICWs[3] : ICWs[2]))
                        next_state = RUN;
                end
                RUN: begin
                    if (inta_fall) begin
                        ack_first  = 1'b1;
                        next_state = ACK1;
                    end
                end
                ACK1: begin
                    if (vec_oe) begin
                        if (inta_n) begin
                            ack_end    = 1'b1;
                            next_state = RUN;
                        end
                    end else if (inta_fall) begin
                        ack_second = 1'b1;
                    end
                end
                default: next_state = INIT;
            endcase
        end
    end

    // EOI clears are applied before the acknowledge set so both take effect
    always_comb begin
        irr_nxt = ltim ? ir : (irr | (ir & ~ir_prev));
        isr_nxt = isr;
        if (state != INIT && OCWs[2]) begin
            if (datatologic[7:5] == 3'b001 && isr != 8'h00)
                isr_nxt[isr_top[2:0]] = 1'b0;
            else if (datatologic[7:5] == 3'b011)
                isr_nxt[datatologic[2:0]] = 1'b0;
        end
        if (ack_first && win_found) begin
            isr_nxt[win_level] = 1'b1;
            irr_nxt[win_level] = 1'b0;
        end
        if (ack_end && aeoi && !spurious)
            isr_nxt[level] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inta_prev <= 1'b1;
        end else begin
            inta_prev <= inta_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isr      <= 8'h00;
            irr      <= 8'h00;
            imr      <= 8'h00;
            ir_prev  <= 8'h00;
            ltim     <= 1'b0;
            sngl     <= 1'b0;
            ic4      <= 1'b0;
            aeoi     <= 1'b0;
            base     <= 5'd0;
            level    <= 3'd0;
            spurious <= 1'b0;
            vec_oe   <= 1'b0;
            rd_isr   <= 1'b0;
        end else if (ICWs[1]) begin
            ltim     <= datatologic[3];
            sngl     <= datatologic[1];
            ic4      <= datatologic[0];
            isr      <= 8'h00;
            irr      <= 8'h00;
            imr      <= 8'h00;
            ir_prev  <= 8'h00;
            level    <= 3'd0;
            spurious <= 1'b0;
            vec_oe   <= 1'b0;
            rd_isr   <= 1'b0;
        end else begin
            ir_prev <= ir;
            irr     <= irr_nxt;
            isr     <= isr_nxt;
            if (ICWs[2]) base <= datatologic[7:3];
            if (ICWs[4]) aeoi <= datatologic[1];
            if (state != INIT) begin
                if (OCWs[1]) imr <= datatologic;
                if (OCWs[3] && datatologic[1]) rd_isr <= datatologic[0];
            end
            if (ack_first) begin
                level    <= win_found ? win_level : 3'd7;
                spurious <= ~win_found;
            end
            if (ack_second) vec_oe <= 1'b1;
            if (ack_end)    vec_oe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pic_control_logic.sv
// Directed-vector bench for pic_control_logic: init sequences, priority,
// masking, EOI, AEOI, spurious acknowledge, re-init and reset during acknowledge.
module tb_pic_control_logic;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:1] ICWs;
    logic [3:1] OCWs;
    logic [7:0] datatologic;
    logic [7:0] ir;
    logic       inta_n;
    logic       intr;
    logic [7:0] isr, irr, imr, vector;
    logic       vec_oe, rd_isr;

    int nvec = 0;
    int nmis = 0;

    pic_control_logic dut (
        .clk(clk), .rst_n(rst_n), .ICWs(ICWs), .OCWs(OCWs),
        .datatologic(datatologic), .ir(ir), .inta_n(inta_n),
        .intr(intr), .isr(isr), .irr(irr), .imr(imr),
        .vector(vector), .vec_oe(vec_oe), .rd_isr(rd_isr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic icw(input int n, input logic [7:0] d);
        ICWs = 4'b0001 << (n - 1);
        datatologic = d;
        tick();
        ICWs = 4'b0000;
    endtask

    task automatic ocw(input int n, input logic [7:0] d);
        OCWs = 3'b001 << (n - 1);
        datatologic = d;
        tick();
        OCWs = 3'b000;
    endtask

    task automatic inta_lo;
        inta_n = 1'b0;
        tick();
    endtask

    task automatic inta_hi;
        inta_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; ICWs = '0; OCWs = '0; datatologic = '0; ir = '0; inta_n = 1'b1;
        #3;
        check_val("rst isr", isr, 8'h00);
        check_val("rst irr", irr, 8'h00);
        check_val("rst imr", imr, 8'h00);
        check_val("rst vector", vector, 8'h00);
        check_val("rst int/oe/rd", {5'd0, intr, vec_oe, rd_isr}, 8'h00);
        tick(); tick();
        rst_n = 1'b1;

        // basic edge-triggered acknowledge of IR3
        icw(1, 8'h13); icw(2, 8'h40); icw(4, 8'h01);
        ir = 8'h08; tick(); ir = 8'h00;
        check_val("ir3 irr", irr, 8'h08);
        check_val("ir3 int", {7'd0, intr}, 8'h01);
        inta_lo();
        check_val("ack1 isr", isr, 8'h08);
        check_val("ack1 irr", irr, 8'h00);
        check_val("ack1 int", {7'd0, intr}, 8'h00);
        inta_hi(); inta_lo();
        check_val("ack2 oe", {7'd0, vec_oe}, 8'h01);
        check_val("ack2 vector", vector, 8'h43);
        inta_hi();
        check_val("ack end oe", {7'd0, vec_oe}, 8'h00);

        // nested priority: IR5 blocked by IR3 in service, IR1 preempts
        ir = 8'h20; tick();
        check_val("ir5 irr", irr, 8'h20);
        check_val("ir5 int", {7'd0, intr}, 8'h00);
        ir = 8'h22; tick(); ir = 8'h00;
        check_val("ir1 int", {7'd0, intr}, 8'h01);
        inta_lo();
        check_val("nest isr", isr, 8'h0A);
        check_val("nest irr", irr, 8'h20);
        inta_hi(); inta_lo();
        check_val("nest vector", vector, 8'h41);
        inta_hi();
        ocw(2, 8'h20);
        check_val("ns eoi isr", isr, 8'h08);
        check_val("ns eoi int", {7'd0, intr}, 8'h00);
        ocw(2, 8'h63);
        check_val("sp eoi isr", isr, 8'h00);
        check_val("sp eoi int", {7'd0, intr}, 8'h01);
        inta_lo(); inta_hi(); inta_lo();
        check_val("ir5 vector", vector, 8'h45);
        inta_hi();
        ocw(2, 8'h20);
        check_val("ir5 eoi isr", isr, 8'h00);

        // masking
        ocw(1, 8'hFF);
        check_val("mask imr", imr, 8'hFF);
        ir = 8'h01; tick(); ir = 8'h00;
        check_val("mask irr", irr, 8'h01);
        check_val("mask int", {7'd0, intr}, 8'h00);
        ocw(1, 8'h00);
        check_val("unmask int", {7'd0, intr}, 8'h01);
        inta_lo();
        check_val("ir0 isr", isr, 8'h01);
        inta_hi(); inta_lo();
        check_val("ir0 vector", vector, 8'h40);
        inta_hi();
        ocw(2, 8'h20);
        check_val("ir0 eoi isr", isr, 8'h00);

        // OCW3 read select
        ocw(3, 8'h0B);
        check_val("ocw3 set", {7'd0, rd_isr}, 8'h01);
        ocw(3, 8'h09);
        check_val("ocw3 keep", {7'd0, rd_isr}, 8'h01);
        ocw(3, 8'h0A);
        check_val("ocw3 clr", {7'd0, rd_isr}, 8'h00);

        // spurious acknowledge
        inta_lo();
        check_val("spur isr", isr, 8'h00);
        inta_hi(); inta_lo();
        check_val("spur vector", vector, 8'h47);
        check_val("spur oe", {7'd0, vec_oe}, 8'h01);
        inta_hi();
        check_val("spur isr end", isr, 8'h00);

        // automatic EOI
        icw(1, 8'h13);
        check_val("reinit isr", isr, 8'h00);
        icw(2, 8'h88); icw(4, 8'h03);
        ir = 8'h40; tick(); ir = 8'h00;
        check_val("aeoi irr", irr, 8'h40);
        inta_lo(); inta_hi(); inta_lo();
        check_val("aeoi vector", vector, 8'h8E);
        check_val("aeoi isr held", isr, 8'h40);
        inta_hi();
        check_val("aeoi isr clr", isr, 8'h00);
        check_val("aeoi oe", {7'd0, vec_oe}, 8'h00);

        // level mode, single=0, no ICW4: ICW3 ends init
        icw(1, 8'h18); icw(2, 8'h40);
        ir = 8'h04; tick();
        check_val("lvl init irr", irr, 8'h04);
        check_val("lvl init int", {7'd0, intr}, 8'h00);
        icw(3, 8'h00);
        check_val("lvl run int", {7'd0, intr}, 8'h01);
        ir = 8'h00; tick();
        check_val("lvl drop irr", irr, 8'h00);
        check_val("lvl drop int", {7'd0, intr}, 8'h00);

        // ICW1 while in ACK1
        ocw(1, 8'h80);
        ir = 8'h02; tick(); ir = 8'h00;
        inta_lo();
        check_val("ackre isr", isr, 8'h02);
        icw(1, 8'h13);
        check_val("ackre isr clr", isr, 8'h00);
        check_val("ackre irr clr", irr, 8'h00);
        check_val("ackre imr clr", imr, 8'h00);
        check_val("ackre int", {7'd0, intr}, 8'h00);
        inta_hi(); inta_lo();
        check_val("init inta oe", {7'd0, vec_oe}, 8'h00);
        inta_hi();

        // reset in the middle of an acknowledge
        icw(2, 8'h40); icw(4, 8'h01);
        ocw(3, 8'h0B);
        ir = 8'h10; tick(); ir = 8'h00;
        inta_lo(); inta_hi(); inta_lo();
        check_val("pre-rst oe", {7'd0, vec_oe}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid rst isr", isr, 8'h00);
        check_val("mid rst irr", irr, 8'h00);
        check_val("mid rst imr", imr, 8'h00);
        check_val("mid rst vector", vector, 8'h00);
        check_val("mid rst int/oe/rd", {5'd0, intr, vec_oe, rd_isr}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/pic_control_logic.md
PIC_CONTROL_LOGIC -- requirements
Module: pic_control_logic

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other inputs SHALL be synchronous to clk.
REQ-002 clk  input  1  system clock, all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ICWs  input  [4:1]  one-cycle strobes marking datatologic as ICW1..ICW4.
REQ-005 OCWs  input  [3:1]  one-cycle strobes marking datatologic as OCW1..OCW3.
REQ-006 datatologic  input  8  command byte accompanying a strobe.
REQ-007 ir  input  8  interrupt request lines; IR0 is highest priority.
REQ-008 inta_n  input  1  interrupt acknowledge from the CPU, active low.
REQ-009 int  output  1  interrupt request to the CPU.
REQ-010 isr, irr, imr  output  8 each  in-service, request and mask registers.
REQ-011 vector  output  8  interrupt vector {ICW2[7:3], level[2:0]}.
REQ-012 vec_oe  output  1  high while vector is to be driven onto D.
REQ-013 rd_isr  output  1  OCW3 read select: 1 = ISR, 0 = IRR.

Function
REQ-014 States SHALL be INIT, RUN, ACK1; transitions occur only on the rising edge of clk.
REQ-015 An ICW1 strobe in any state SHALL enter INIT and clear isr, irr, imr, rd_isr and the edge history, and latch LTIM = bit3, SNGL = bit1, IC4 = bit0.
REQ-016 An ICW2 strobe SHALL latch vector base bits [7:3]; ICW3 SHALL be accepted and ignored; an ICW4 strobe SHALL latch AEOI = bit1.
REQ-017 INIT SHALL go to RUN on the strobe of the last expected ICW: ICW4 if IC4=1, else ICW3 if SNGL=0, else ICW2.
REQ-018 In INIT, OCW strobes and inta_n SHALL be ignored and int SHALL be 0.
REQ-019 Level mode (LTIM=1): irr[i] SHALL follow ir[i] every cycle.
REQ-020 Edge mode (LTIM=0): irr[i] SHALL set on a 0->1 of ir[i] between consecutive clocks, and clear only on acknowledge or ICW1.
REQ-021 int SHALL be combinationally 1 in RUN when some bit of irr & ~imr has strictly higher priority than the highest set isr bit, or any such bit exists when isr = 0.
REQ-022 OCW1 SHALL load imr; masking SHALL not alter irr or isr.
REQ-023 OCW2 with bits[7:5]=001 (non-specific EOI) SHALL clear the highest-priority set isr bit; 011 (specific EOI) SHALL clear isr[bits 2:0]; all other codes SHALL be ignored.
REQ-024 OCW3 with bit1=1 SHALL set rd_isr to bit0; bit1=0 SHALL leave rd_isr unchanged.
REQ-025 A falling edge of inta_n (registered compare) in RUN SHALL latch the winning level, set its isr bit, clear its irr bit, and enter ACK1.
REQ-026 If int=0 at that first falling edge, the level SHALL be 7 (spurious) and isr SHALL not change.
REQ-027 In ACK1 the second falling edge of inta_n SHALL assert vec_oe with vector = {base, level} from the next cycle until inta_n returns high, then return to RUN.
REQ-028 With AEOI=1, the acknowledged isr bit SHALL clear on the cycle inta_n rises after the second pulse; spurious acknowledges never set isr.
REQ-029 When acknowledge-clear and edge-set hit the same irr bit in one cycle, clear SHALL win; an EOI and an acknowledge in the same cycle SHALL both apply.
REQ-030 int SHALL be 0 while in ACK1.

Reset
REQ-031 On rst_n low: state = INIT; isr, irr, imr = 0x00; int, vec_oe, rd_isr = 0; vector = 0x00; LTIM, SNGL, IC4, AEOI, base = 0; edge history = 0.
REQ-032 Release of rst_n SHALL take effect on the next rising clk with no extra delay cycles.

Verification
REQ-033 ICW1=0x13, ICW2=0x40, ICW4=0x01; pulse ir[3] -> irr=0x08, int=1; two inta_n pulses -> isr=0x08, irr=0x00, vector=0x43 with vec_oe=1 during the second pulse.
REQ-034 isr=0x08 in service, raise ir[5] then ir[1] -> int stays 0 for IR5 and asserts for IR1; ack gives vector=0x41, isr=0x0A; non-specific EOI (OCW2=0x20) -> isr=0x08.
REQ-035 OCW1=0xFF with ir[0] pulsed -> irr=0x01, int=0; OCW1=0x00 -> int=1 next cycle.
REQ-036 ICW4=0x03 (AEOI), ack IR6 -> vector=base|6, isr returns to 0x00 when inta_n rises after the second pulse.
REQ-037 inta_n pulsed twice with no request -> vector=base|7, isr=0x00; ICW1 issued while in ACK1 -> INIT, all registers 0x00, int=0; rst_n low mid-ack -> all outputs at reset values.
